// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: opcode, funct, ALUOp, ALUControl encodings and the control FSM state type.
package mips_ctrl_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;
endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: instruction/status inputs and per-cycle datapath controls.
interface multicycle_control_if;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       mem_ready;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [2:0] ALUControl;
  logic [1:0] PCSrc;
  logic       PCEn;
  logic       instr_done;
  logic       illegal_op;
  logic [3:0] state;
  modport master (
    input  Op, Funct, Zero, mem_ready,
    output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB,
           ALUOp, ALUControl, PCSrc, PCEn, instr_done, illegal_op, state
  );
  modport slave (
    output Op, Funct, Zero, mem_ready,
    input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB,
           ALUOp, ALUControl, PCSrc, PCEn, instr_done, illegal_op, state
  );
endinterface

// File: rtl/alu_decoder.sv
// alu_decoder: maps (ALUOp, Funct) to the ALU operation select.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_control_o
);
  always_comb
    alu_control_o = alu_op_i == ALUOP_SUB   ? ALU_SUB :
                    alu_op_i != ALUOP_FUNCT ? ALU_ADD :
                    funct_i == FN_SUB ? ALU_SUB :
                    funct_i == FN_AND ? ALU_AND :
                    funct_i == FN_OR  ? ALU_OR  :
                    funct_i == FN_SLT ? ALU_SLT : ALU_ADD;
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle MIPS control FSM with memory-ready stalls.
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  multicycle_control_if.master bus
);
  state_t     state_q, state_d;
  logic [1:0] alu_op;
  logic       irw, memw, regw, pcen, done, ill;
  always_ff @(posedge clk)
    state_q <= reset ? FETCH : state_d;
  always_comb begin
    state_d      = state_q;
    alu_op       = ALUOP_ADD;
    irw          = 1'b0;
    memw         = 1'b0;
    regw         = 1'b0;
    pcen         = 1'b0;
    done         = 1'b0;
    ill          = 1'b0;
    bus.IorD     = 1'b0;
    bus.RegDst   = 1'b0;
    bus.MemtoReg = 1'b0;
    bus.ALUSrcA  = 1'b0;
    bus.ALUSrcB  = 2'b00;
    bus.PCSrc    = 2'b00;
    case (state_q)
      FETCH: begin
        bus.ALUSrcB = 2'b01;
        irw         = bus.mem_ready;
        pcen        = bus.mem_ready;
        state_d     = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        bus.ALUSrcB = 2'b11;
        case (bus.Op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default: begin
            state_d = FETCH;
            ill     = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        state_d     = bus.Op == OP_SW ? MEMWR : MEMRD;
      end
      MEMRD: begin
        bus.IorD = 1'b1;
        state_d  = bus.mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        bus.MemtoReg = 1'b1;
        regw         = 1'b1;
        done         = 1'b1;
        state_d      = FETCH;
      end
      MEMWR: begin
        bus.IorD = 1'b1;
        memw     = 1'b1;
        done     = bus.mem_ready;
        state_d  = bus.mem_ready ? FETCH : MEMWR;
      end
      EXECUTE: begin
        bus.ALUSrcA = 1'b1;
        alu_op      = ALUOP_FUNCT;
        state_d     = ALUWB;
      end
      ALUWB: begin
        bus.RegDst = 1'b1;
        regw       = 1'b1;
        done       = 1'b1;
        state_d    = FETCH;
      end
      BRANCH: begin
        bus.ALUSrcA = 1'b1;
        alu_op      = ALUOP_SUB;
        bus.PCSrc   = 2'b01;
        pcen        = bus.Zero;
        done        = 1'b1;
        state_d     = FETCH;
      end
      ADDIEX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        state_d     = ADDIWB;
      end
      ADDIWB: begin
        regw    = 1'b1;
        done    = 1'b1;
        state_d = FETCH;
      end
      JUMP: begin
        bus.PCSrc = 2'b10;
        pcen      = 1'b1;
        done      = 1'b1;
        state_d   = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end
  // Strobes are masked during reset so an abandoned instruction never writes.
  assign bus.IRWrite    = irw & ~reset;
  assign bus.MemWrite   = memw & ~reset;
  assign bus.RegWrite   = regw & ~reset;
  assign bus.PCEn       = pcen & ~reset;
  assign bus.instr_done = done & ~reset;
  assign bus.illegal_op = ill & ~reset;
  assign bus.ALUOp      = alu_op;
  assign bus.state      = state_q;
  alu_decoder u_alu_decoder (
    .alu_op_i      (alu_op),
    .funct_i       (bus.Funct),
    .alu_control_o (bus.ALUControl)
  );
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle MIPS control FSM: sequences one shared ALU, one unified instruction/data memory and the register file over several clock cycles per instruction. It replaces the single-cycle decoder in the multi-cycle datapath variant. It decodes Op and Funct and drives per-cycle mux selects and write enables. It stalls on a memory-ready handshake.

## Interface
Parameters:
- none; opcode, funct, state and ALUOp encodings come from the shared package.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high.
- Op  in  6  instruction bits [31:26], valid from the IR once DECODE is reached.
- Funct  in  6  instruction bits [5:0].
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- IorD  out  1  0 = PC addresses memory; 1 = ALUOut addresses memory.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction register load.
- RegDst  out  1  1 = rd, 0 = rt.
- MemtoReg  out  1  1 = data register, 0 = ALUOut.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  0 = PC, 1 = register A.
- ALUSrcB  out  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left by 2.
- ALUOp  out  2  00 = add, 01 = sub, 10 = decode Funct.
- ALUControl  out  3  final ALU operation.
- PCSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- PCEn  out  1  PC load enable.
- instr_done  out  1  one-cycle pulse in the final cycle of a retired instruction.
- illegal_op  out  1  one-cycle pulse when an unknown opcode is decoded.
- state  out  4  current state, for debug.

## Operation
States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.

Per-state transitions and outputs (outputs not listed are 0):
- FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00. IRWrite and PCEn equal mem_ready. Stay while !mem_ready; else go to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by Op:
  - 100011 (LW) or 101011 (SW) → MEMADR
  - 000000 (R-type) → EXECUTE
  - 000100 (BEQ) → BRANCH
  - 001000 (ADDI) → ADDIEX
  - 000010 (J) → JUMP
  - any other Op → FETCH, with illegal_op=1.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. LW → MEMRD; SW → MEMWR.
- MEMRD: IorD=1. Stay while !mem_ready; else → MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1. → FETCH.
- MEMWR: IorD=1, MemWrite=1 (held until ready). Stay while !mem_ready; on mem_ready, instr_done=1 and → FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. → ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1, instr_done=1. → FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, PCEn=Zero, instr_done=1. → FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. → ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1, instr_done=1. → FETCH.
- JUMP: PCSrc=10, PCEn=1, instr_done=1. → FETCH.

ALUControl decode:
- ALUOp 00 → 010 (add); ALUOp 01 → 110 (sub).
- ALUOp 10, by Funct:
  - 100000 → 010 (add)
  - 100010 → 110 (sub)
  - 100100 → 000 (and)
  - 100101 → 001 (or)
  - 101010 → 111 (slt)
  - any other Funct → 010.
- ALUOp 11 is never produced; it decodes to 010.

## Timing
- The state register is the only storage. All outputs are combinational from state, plus Op, Zero and mem_ready where noted above.
- Reset:
  - While reset=1, MemWrite, IRWrite, RegWrite, PCEn, instr_done and illegal_op are forced to 0.
  - The cycle after reset is sampled, state=FETCH.
  - Reset asserted mid-instruction abandons that instruction with no write strobes.
- Latency in cycles, FETCH to retire, with mem_ready held high: R-type 4, LW 5, SW 4, BEQ 3, ADDI 4, J 3, illegal opcode 2.
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle. During such a wait, outputs hold and no write enable other than MemWrite (in MEMWR) is asserted.
- mem_ready is ignored in every state except FETCH, MEMRD and MEMWR.
- BEQ not taken: PCEn=0, and the PC keeps PC+4 from the fetch.

## Structure
- Package mips_ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J);
  - funct constants;
  - the ALUOp and ALUControl encodings;
  - the state enum typedef, 4-bit, with FETCH=0.
- Sub-module alu_decoder maps (ALUOp, Funct) to ALUControl. It is purely combinational and reused by the single-cycle top.

## Test plan
- Reset mid-LW (state=MEMRD), then release → state=FETCH the next cycle; RegWrite=0 and MemWrite=0 throughout reset.
- R-type add (Op=000000, Funct=100000), mem_ready=1 → states FETCH, DECODE, EXECUTE, ALUWB; ALUControl=010 in EXECUTE; RegWrite=1 and RegDst=1 in cycle 4; instr_done=1 only in cycle 4.
- LW with mem_ready=0 for 2 cycles in FETCH and 3 cycles in MEMRD → retire in cycle 10; IRWrite=1 only in the fetch cycle with mem_ready=1; MemtoReg=1 and RegWrite=1 in MEMWB.
- BEQ with Zero=1, then BEQ with Zero=0 → PCEn=1 with PCSrc=01 in BRANCH for the first; PCEn=0 for the second; both retire in 3 cycles.
- SW with mem_ready=0 for 2 cycles in MEMWR → MemWrite high for 3 consecutive cycles, instr_done only on the last; J → PCSrc=10 and PCEn=1, 3 cycles.
- Op=111111 → illegal_op=1 in DECODE, state=FETCH next, no RegWrite/MemWrite/PCEn beyond the fetch; Funct=100111 under R-type → ALUControl=010.
